mmu_mem_router: RTL

// - N-port memory request router: successor to the single-port MMU path. Arbitrates NUM_PORTS requestors
//   (instruction fetch, data load/store, debug, ...) round-robin onto one shared memory path.
// - Address decode: boot ROM window (async read), RAM window (variable-latency handshake backend), else bus error.
// - One transaction in flight; every accepted request gets exactly one response (data, write-ack or error).
// - Adds a backend timeout, byte-lane writes, misalignment errors and per-port error reporting.

---
 rtl/mmu_pkg.sv | 39 +++
 rtl/mmu_rr_arbiter.sv | 30 +++
 rtl/mmu_mem_router.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared types and address-window decode for the N-port memory router.
package mmu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROM_RD,
    ST_RAM_REQ,
    ST_RAM_WAIT,
    ST_RESP
  } mmu_state_e;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_ERR
  } region_e;

  localparam int unsigned DEF_ROM_ADDR_SIZE  = 16;
  localparam logic [31:0] DEF_RAM_BASE       = 32'h0001_0000;
  localparam logic [31:0] DEF_RAM_SIZE       = 32'h0010_0000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  // RAM is checked first so it wins wherever the two windows overlap.
  function automatic region_e region_decode(
    input logic [31:0] addr,
    input int unsigned rom_addr_size,
    input logic [31:0] ram_base,
    input logic [31:0] ram_size
  );
    logic [33:0] rom_bytes;
    logic [32:0] ram_end;
    rom_bytes = 34'(1) << (rom_addr_size + 2);
    ram_end   = {1'b0, ram_base} + {1'b0, ram_size};
    if (({1'b0, addr} >= {1'b0, ram_base}) && ({1'b0, addr} < ram_end)) return REG_RAM;
    if ({2'b00, addr} < rom_bytes) return REG_ROM;
    return REG_ERR;
  endfunction

endpackage

// File: rtl/mmu_rr_arbiter.sv
// Rotating-priority arbiter: the first requester after rr_i (mod N) wins.
module mmu_rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] rr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (32'(rr_i) + off) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = PW'(cand);
        gnt_o   = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/mmu_mem_router.sv
// N-port router: round-robin arbitration onto one ROM/RAM path, one transaction in flight,
// with backend timeout, byte-lane writes and per-request error responses.
module mmu_mem_router
  import mmu_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ROM_ADDR_SIZE  = DEF_ROM_ADDR_SIZE,
  parameter logic [31:0] RAM_BASE       = DEF_RAM_BASE,
  parameter logic [31:0] RAM_SIZE       = DEF_RAM_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_PORTS-1:0]      p_req_i,
  input  logic [NUM_PORTS-1:0]      p_we_i,
  input  logic [NUM_PORTS*32-1:0]   p_addr_i,
  input  logic [NUM_PORTS*32-1:0]   p_wdata_i,
  input  logic [NUM_PORTS*4-1:0]    p_be_i,
  output logic [NUM_PORTS-1:0]      p_gnt_o,
  output logic [NUM_PORTS-1:0]      p_rvalid_o,
  output logic [31:0]               p_rdata_o,
  output logic                      p_err_o,
  output logic [ROM_ADDR_SIZE-1:0]  rom_addr_o,
  input  logic [31:0]               rom_data_i,
  output logic                      ram_req_o,
  output logic                      ram_we_o,
  output logic [31:0]               ram_addr_o,
  output logic [31:0]               ram_wdata_o,
  output logic [3:0]                ram_be_o,
  input  logic                      ram_gnt_i,
  input  logic                      ram_rvalid_i,
  input  logic [31:0]               ram_rdata_i
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  mmu_state_e    state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, owner_q, owner_d;
  logic          we_q, we_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, tmo_q, tmo_d;
  logic [3:0]    be_q, be_d;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [31:0]          sel_addr;
  logic                 sel_we;
  logic [3:0]           sel_be;
  region_e              sel_region;
  logic                 tmo_hit;

  mmu_rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
    .req_i   (p_req_i),
    .rr_i    (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_addr   = p_addr_i[32*arb_idx +: 32];
  assign sel_we     = p_we_i[arb_idx];
  assign sel_be     = p_be_i[4*arb_idx +: 4];
  assign sel_region = region_decode(sel_addr, ROM_ADDR_SIZE, RAM_BASE, RAM_SIZE);
  // Backend gets exactly TIMEOUT_CYCLES cycles; a completion in the last one still wins.
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_q == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rr_q    <= PW'(NUM_PORTS - 1);
      owner_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          rr_d    = arb_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = p_wdata_i[32*arb_idx +: 32];
          be_d    = sel_be;
          tmo_d   = '0;
          if ((sel_addr[1:0] != 2'b00) || (sel_region == REG_ERR) ||
              ((sel_region == REG_ROM) && sel_we)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (sel_region == REG_ROM) begin
            state_d = ST_ROM_RD;
          end else if (sel_we && (sel_be == 4'b0000)) begin
            state_d = ST_RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = ST_RAM_REQ;
          end
        end
      end
      ST_ROM_RD: begin
        rdata_d = rom_data_i;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RAM_REQ: begin
        tmo_d = tmo_q + 32'd1;
        if (ram_gnt_i) begin
          if (we_q) begin
            state_d = ST_RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = ST_RAM_WAIT;
          end
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RAM_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (ram_rvalid_i) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = ram_rdata_i;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign p_gnt_o     = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign p_rvalid_o  = (state_q == ST_RESP) ? (NUM_PORTS'(1) << owner_q) : '0;
  assign p_rdata_o   = rdata_q;
  assign p_err_o     = err_q;
  assign rom_addr_o  = addr_q[ROM_ADDR_SIZE+1:2];
  assign ram_req_o   = (state_q == ST_RAM_REQ);
  assign ram_we_o    = ram_req_o & we_q;
  assign ram_addr_o  = ram_req_o ? (addr_q - RAM_BASE) : '0;
  assign ram_wdata_o = ram_req_o ? wdata_q : '0;
  assign ram_be_o    = ram_req_o ? be_q : '0;

endmodule
